// File: rtl/mcore_pkg.sv
// mcore shared definitions: instruction layout, opcodes, ALU functs, FSM states.
package mcore_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned REG_N   = 16;
  localparam int unsigned RADDR_W = 4;

  localparam logic [3:0] OP_RALU = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLT = 4'd5;
  localparam logic [3:0] FN_SLL = 4'd6;
  localparam logic [3:0] FN_SRL = 4'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Instruction word; the jump target is {rs, rt, imm}.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] imm;
  } instr_t;

endpackage

// File: rtl/mcore_regfile.sv
// 16-entry register file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module mcore_regfile
  import mcore_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]  rdata_a_o,
  input  logic [RADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]  rdata_b_o,
  input  logic               we_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  wdata_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // Register storage; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mcore.sv
// mcore: multi-cycle 20-bit-instruction core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional feature: define MCORE_BNE_EN to execute opcode 5 as BNE; otherwise it is a NOP.
module mcore
  import mcore_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              halted_q, halted_d;

  logic [RADDR_W-1:0] rf_raddr_b;
  logic [DATA_W-1:0]  rf_rdata_a, rf_rdata_b;
  logic               rf_we;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic              a_eq_b;

  mcore_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (ir_q.rs),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (rf_raddr_b),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (ir_q.rd),
    .wdata_i   (res_q)
  );

  assign imm_ext = {{(DATA_W-4){ir_q.imm[3]}}, ir_q.imm};
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_br   = pc_inc + {{(PC_W-4){ir_q.imm[3]}}, ir_q.imm};
  assign a_eq_b  = (a_q == b_q);

  // R-type ALU on the decoded operands.
  always_comb begin
    alu_res = '0;
    case (ir_q.imm)
      FN_ADD:  alu_res = a_q + b_q;
      FN_SUB:  alu_res = a_q - b_q;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_XOR:  alu_res = a_q ^ b_q;
      FN_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
      FN_SLL:  alu_res = a_q << b_q[3:0];
      FN_SRL:  alu_res = a_q >> b_q[3:0];
      default: alu_res = '0;
    endcase
  end

  // Next-state, datapath and request control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    halted_d     = halted_q;
    rf_we        = 1'b0;
    // Port B reads rt while decoding and the store source rd while executing.
    rf_raddr_b   = (state_q == ST_EXEC) ? ir_q.rd : ir_q.rt;

    case (state_q)
      ST_FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          imem_req_d = 1'b0;
          ir_d       = instr_t'(imem_rdata);
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        a_d     = rf_rdata_a;
        b_d     = rf_rdata_b;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        case (ir_q.op)
          OP_RALU: begin
            res_d   = alu_res;
            state_d = ST_WB;
          end
          OP_ADDI: begin
            res_d   = a_q + imm_ext;
            state_d = ST_WB;
          end
          OP_LW, OP_SW: begin
            dmem_addr_d  = a_q + imm_ext;
            dmem_we_d    = (ir_q.op == OP_SW);
            dmem_wdata_d = rf_rdata_b;
            dmem_req_d   = 1'b1;
            state_d      = ST_MEM;
          end
          OP_BEQ: begin
            pc_d       = a_eq_b ? pc_br : pc_inc;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end
`ifdef MCORE_BNE_EN
          OP_BNE: begin
            pc_d       = a_eq_b ? pc_inc : pc_br;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end
`endif
          OP_JMP: begin
            pc_d       = PC_W'({ir_q.rs, ir_q.rt, ir_q.imm});
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            pc_d       = pc_inc;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dmem_we_q) begin
            pc_d       = pc_inc;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we      = 1'b1;
        pc_d       = pc_inc;
        imem_req_d = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_mcore.sv
// Bench for mcore: ISA-level model plus memory responder, directed program, reset scenarios.
module tb_mcore;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [19:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic [PC_W-1:0]   pc;
  logic              halted;

  always #5 clk = ~clk;

  mcore #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .halted     (halted)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Environment memories.
  logic [19:0]       prog [4096];
  logic [DATA_W-1:0] dmem [16];

  // Instruction-level model.
  logic [DATA_W-1:0] m_reg [16];
  logic [PC_W-1:0]   m_pc;
  logic              m_halt;
  logic              exp_valid;
  logic              exp_we;
  logic [DATA_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;

  // Hand-computed store trace of the program.
  logic [DATA_W-1:0] lit_addr [14];
  logic [DATA_W-1:0] lit_data [14];
  int                lit_idx;

  // Responder control.
  int   dmem_wait;
  logic late_mode;
  logic prev_rst;
  int   icnt, dcnt;
  logic iwait, dwait;
  logic [PC_W-1:0]   iprev_addr;
  logic              dprev_we;
  logic [DATA_W-1:0] dprev_addr, dprev_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pc      = '0;
    m_halt    = 1'b0;
    exp_valid = 1'b0;
    lit_idx   = 0;
  endtask

  // Execute one instruction architecturally.
  task automatic m_step(input logic [19:0] ins);
    logic [3:0]        op, rd, rs, rt, fn;
    logic [DATA_W-1:0] a, b, imm, val, addr;
    logic [PC_W-1:0]   nxt;
    logic              wr;
    op = ins[19:16]; rd = ins[15:12]; rs = ins[11:8]; rt = ins[7:4]; fn = ins[3:0];
    a = m_reg[rs]; b = m_reg[rt];
    imm = {{(DATA_W-4){fn[3]}}, fn};
    addr = a + imm;
    nxt = m_pc + PC_W'(1);
    wr = 1'b0; val = '0;
    case (op)
      4'd0: begin
        wr = 1'b1;
        case (fn)
          4'd0: val = a + b;
          4'd1: val = a - b;
          4'd2: val = a & b;
          4'd3: val = a | b;
          4'd4: val = a ^ b;
          4'd5: val = ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
          4'd6: val = a << b[3:0];
          4'd7: val = a >> b[3:0];
          default: val = '0;
        endcase
      end
      4'd1: begin wr = 1'b1; val = a + imm; end
      4'd2: begin
        wr = 1'b1; val = dmem[addr[3:0]];
        exp_valid = 1'b1; exp_we = 1'b0; exp_addr = addr; exp_wdata = '0;
      end
      4'd3: begin
        exp_valid = 1'b1; exp_we = 1'b1; exp_addr = addr; exp_wdata = m_reg[rd];
      end
      4'd4: if (a == b) nxt = m_pc + PC_W'(1) + {{(PC_W-4){fn[3]}}, fn};
`ifdef MCORE_BNE_EN
      4'd5: if (a != b) nxt = m_pc + PC_W'(1) + {{(PC_W-4){fn[3]}}, fn};
`endif
      4'd6: nxt = PC_W'(ins[11:0]);
      4'd15: begin m_halt = 1'b1; nxt = m_pc; end
      default: ;
    endcase
    if (wr && rd != 4'd0) m_reg[rd] = val;
    m_pc = nxt;
  endtask

  // Memory responder and per-cycle checker, sampling on the falling edge.
  task automatic run_responder();
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (!rst_n) begin
        m_reset();
        icnt = 0; dcnt = 0; iwait = 1'b0; dwait = 1'b0; prev_rst = 1'b0;
      end else begin
        if (!prev_rst && late_mode) begin
          dmem_ack   = 1'b1;
          dmem_rdata = 16'hDEAD;
        end
        prev_rst = 1'b1;
        check("req_exclusive", 32'(imem_req & dmem_req), 32'd0);
        if (imem_req) begin
          if (iwait) check("imem_addr_stable", 32'(imem_addr), 32'(iprev_addr));
          if (icnt >= int'(imem_addr[0])) begin
            check("fetch_addr", 32'(imem_addr), 32'(m_pc));
            imem_ack   = 1'b1;
            imem_rdata = prog[imem_addr[11:0]];
            m_step(imem_rdata);
            icnt = 0; iwait = 1'b0;
          end else begin
            icnt++; iwait = 1'b1; iprev_addr = imem_addr;
          end
        end
        if (dmem_req) begin
          if (dwait) begin
            check("dmem_addr_stable", 32'(dmem_addr), 32'(dprev_addr));
            check("dmem_we_stable", 32'(dmem_we), 32'(dprev_we));
            check("dmem_wdata_stable", 32'(dmem_wdata), 32'(dprev_wdata));
          end
          if (dcnt >= dmem_wait) begin
            check("dmem_expected", 32'(exp_valid), 32'd1);
            check("dmem_we", 32'(dmem_we), 32'(exp_we));
            check("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
            if (dmem_we) begin
              check("dmem_wdata", 32'(dmem_wdata), 32'(exp_wdata));
              if (lit_idx < 14) begin
                check("store_lit_addr", 32'(dmem_addr), 32'(lit_addr[lit_idx]));
                check("store_lit_data", 32'(dmem_wdata), 32'(lit_data[lit_idx]));
              end else begin
                check("store_extra", 32'(lit_idx), 32'd13);
              end
              lit_idx++;
              dmem[dmem_addr[3:0]] = dmem_wdata;
            end else begin
              dmem_rdata = dmem[dmem_addr[3:0]];
            end
            dmem_ack  = 1'b1;
            exp_valid = 1'b0;
            dcnt = 0; dwait = 1'b0;
          end else begin
            dcnt++; dwait = 1'b1;
            dprev_addr = dmem_addr; dprev_we = dmem_we; dprev_wdata = dmem_wdata;
          end
        end
      end
    end
  endtask

  task automatic wait_halt();
    for (int n = 0; n < 4000 && !halted; n++) begin
      @(posedge clk); #2;
    end
    check("halted", 32'(halted), 32'd1);
    check("model_halted", 32'(m_halt), 32'd1);
    check("halt_pc", 32'(pc), 32'h00FFF);
    check("stores_seen", 32'(lit_idx), 32'd14);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_dmem_we"},  32'(dmem_we),  32'd0);
    check({tag, "_halted"},   32'(halted),   32'd0);
    check({tag, "_pc"},       32'(pc),       32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) prog[i] = 20'h70000;
    for (int i = 0; i < 16; i++) dmem[i] = DATA_W'(16'hA000 + i);
    prog[0]  = 20'h11005; // ADDI r1,r0,5
    prog[1]  = 20'h1200D; // ADDI r2,r0,-3
    prog[2]  = 20'h03120; // add r3,r1,r2
    prog[3]  = 20'h04215; // slt r4,r2,r1
    prog[4]  = 20'h31004; // SW r1,[r0+4]
    prog[5]  = 20'h25004; // LW r5,[r0+4]
    prog[6]  = 20'h33001; // SW r3,[r0+1]
    prog[7]  = 20'h34002; // SW r4,[r0+2]
    prog[8]  = 20'h35003; // SW r5,[r0+3]
    prog[9]  = 20'h6000A; // JMP 10
    prog[10] = 20'h40112; // BEQ r1,r1,+2 -> 13
    prog[13] = 20'h60014; // JMP 20
    prog[20] = 20'h50112; // BNE r1,r1,+2 -> 21
    prog[21] = 20'h50122; // BNE r1,r2,+2 -> 24 (or 22 as NOP)
    prog[22] = 20'h40125; // BEQ r1,r2,+5 not taken
    prog[23] = 20'h60018; // JMP 24
    prog[24] = 20'h06121; // sub r6 = 8
    prog[25] = 20'h07122; // and r7 = 0005
    prog[26] = 20'h08123; // or  r8 = FFFD
    prog[27] = 20'h09124; // xor r9 = FFF8
    prog[28] = 20'h0A216; // sll r10 = FFA0
    prog[29] = 20'h0B217; // srl r11 = 07FF
    prog[30] = 20'h0C129; // funct 9 r12 = 0
    prog[31] = 20'h0D125; // slt r13 = 0
    prog[32] = 20'h10007; // ADDI r0,r0,7
    prog[33] = 20'h36005;
    prog[34] = 20'h37006;
    prog[35] = 20'h38007;
    prog[36] = 20'h39103;
    prog[37] = 20'h3A104;
    prog[38] = 20'h3B105;
    prog[39] = 20'h3C106;
    prog[40] = 20'h3D107;
    prog[41] = 20'h30200; // SW r0,[r2+0]
    prog[42] = 20'h2E10F; // LW r14,[r1-1]
    prog[43] = 20'h3E000; // SW r14,[r0+0]
    prog[44] = 20'h60FFF; // JMP 0xFFF
    prog[12'hFFF] = 20'hF0000; // HALT

    lit_addr[0]  = 16'd4;    lit_data[0]  = 16'd5;
    lit_addr[1]  = 16'd1;    lit_data[1]  = 16'd2;
    lit_addr[2]  = 16'd2;    lit_data[2]  = 16'd1;
    lit_addr[3]  = 16'd3;    lit_data[3]  = 16'd5;
    lit_addr[4]  = 16'd5;    lit_data[4]  = 16'h0008;
    lit_addr[5]  = 16'd6;    lit_data[5]  = 16'h0005;
    lit_addr[6]  = 16'd7;    lit_data[6]  = 16'hFFFD;
    lit_addr[7]  = 16'd8;    lit_data[7]  = 16'hFFF8;
    lit_addr[8]  = 16'd9;    lit_data[8]  = 16'hFFA0;
    lit_addr[9]  = 16'd10;   lit_data[9]  = 16'h07FF;
    lit_addr[10] = 16'd11;   lit_data[10] = 16'h0000;
    lit_addr[11] = 16'd12;   lit_data[11] = 16'h0000;
    lit_addr[12] = 16'hFFFD; lit_data[12] = 16'h0000;
    lit_addr[13] = 16'd0;    lit_data[13] = 16'd5;

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    late_mode = 1'b0; dmem_wait = 3; prev_rst = 1'b0;
    icnt = 0; dcnt = 0; iwait = 1'b0; dwait = 1'b0;
    iprev_addr = '0; dprev_addr = '0; dprev_we = 1'b0; dprev_wdata = '0;
    m_reset();
    fork
      run_responder();
    join_none

    // Power-on reset, then the first fetch request.
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("por");
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    // Full program run to HALT, then quiescence.
    wait_halt();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      check("halt_no_imem", 32'(imem_req), 32'd0);
      check("halt_no_dmem", 32'(dmem_req), 32'd0);
    end

    // Leave HALT through reset, then reset again in the middle of a stalled store.
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_reset_state("halt_rst");
    dmem_wait = 1000;
    rst_n = 1'b1;
    for (int n = 0; n < 500 && !dmem_req; n++) begin
      @(posedge clk); #2;
    end
    check("mem_reached", 32'(dmem_req), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    check("stall_req", 32'(dmem_req), 32'd1);
    check("stall_we", 32'(dmem_we), 32'd1);
    check("stall_addr", 32'(dmem_addr), 32'd4);
    check("stall_wdata", 32'(dmem_wdata), 32'd5);
    late_mode = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_reset_state("mid_rst");
    rst_n = 1'b1;
    dmem_wait = 3;
    @(posedge clk); #2;
    late_mode = 1'b0;
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_no_dmem", 32'(dmem_req), 32'd0);

    wait_halt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcore.md
MCORE -- requirements
Module: mcore

Interface
REQ-001 Parameter DATA_W, default 16: datapath, register and data-memory word width; must be 8 or more.
REQ-002 Parameter PC_W, default 20: program counter and instruction address width; must be 12 or more.
REQ-003 Ports clk in 1 system clock; rst_n in 1 synchronous active-low reset; only clock domain is clk.
REQ-004 Port imem_req out 1: instruction fetch request, held until acknowledged.
REQ-005 Port imem_addr out PC_W: fetch word address.
REQ-006 Port imem_ack in 1 and imem_rdata in 20: fetch acknowledge and instruction word, sampled in the ack cycle.
REQ-007 Port dmem_req out 1 and dmem_we out 1: data access request and write strobe (1 = store).
REQ-008 Port dmem_addr out DATA_W and dmem_wdata out DATA_W: data word address and store data.
REQ-009 Port dmem_ack in 1 and dmem_rdata in DATA_W: access acknowledge and load data, sampled in the ack cycle.
REQ-010 Port pc out PC_W and halted out 1: current PC; high after HALT executes.

Function
REQ-011 Instruction encoding: op[19:16], rd[15:12], rs[11:8], rt[7:4], imm4/funct[3:0], jump target[11:0].
REQ-012 Multi-cycle FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 FETCH: assert imem_req with imem_addr = pc; on imem_ack latch IR and go to DECODE; wait indefinitely otherwise.
REQ-014 DECODE: read R[rs] and R[rt] into A/B latches; go to EXEC.
REQ-015 Opcodes: 0 R-ALU, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 JMP, 15 HALT; all others are NOPs (pc+1, no writes).
REQ-016 R-ALU funct: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 signed slt (1/0), 6 sll by B[3:0], 7 srl by B[3:0]; funct 8-15 yields 0.
REQ-017 Arithmetic is modulo 2^DATA_W with no flags; imm4 is sign-extended to DATA_W.
REQ-018 EXEC then WB for R-ALU/ADDI: WB writes R[rd], pc <= pc+1, returns to FETCH; ALU ops cost 4 cycles plus fetch wait.
REQ-019 LW/SW: EXEC computes address A+sext(imm4); MEM asserts dmem_req (dmem_we=1 for SW, dmem_wdata=R[rd]) until dmem_ack.
REQ-020 LW: WB writes the dmem_rdata latched in the ack cycle to R[rd]; SW goes from MEM straight to FETCH with pc+1.
REQ-021 BEQ/BNE: compare A and B in EXEC; taken -> pc <= pc+1+sext(imm4); not taken -> pc+1; then FETCH.
REQ-022 JMP: pc <= zero-extended ins[11:0]; then FETCH.
REQ-023 PC arithmetic wraps modulo 2^PC_W.
REQ-024 Register 0 always reads 0; writes to it are discarded.
REQ-025 HALT: halted=1, no further requests; leave only via reset.
REQ-026 imem_req and dmem_req are never asserted together; request outputs stay stable while waiting.

Reset
REQ-027 When rst_n=0 at a clk edge: state=FETCH, pc=0, halted=0, IR=0, imem_req=0, dmem_req=0, dmem_we=0, all registers=0.
REQ-028 Reset mid-access drops the request next cycle; a late ack is ignored.
REQ-029 imem_req first rises in the cycle after rst_n is sampled high.

Configuration
REQ-030 Macro MCORE_BNE_EN defined: opcode 5 executes BNE per REQ-021.
REQ-031 Macro MCORE_BNE_EN undefined: opcode 5 is a NOP; no comparator inverse path is synthesised.

Structure
REQ-032 Package mcore_pkg holds the opcode constants, ALU funct constants and the FSM state type.
REQ-033 Sub-module mcore_regfile: 16 x DATA_W, two asynchronous read ports, one synchronous write port, register 0 fixed to zero.

Verification
REQ-034 ADDI r1,r0,5; ADDI r2,r0,-3; R-ALU add r3,r1,r2 -> r3=2; slt r4,r2,r1 -> r4=1.
REQ-035 SW r1 to [r0+4] with dmem_ack after 3 wait cycles -> dmem_addr=4, wdata=5 held stable; LW r5,[r0+4] -> r5=5.
REQ-036 BEQ r1,r1,+2 at pc=10 -> next fetch at 13; BNE r1,r1 with macro -> 11, without macro -> 11 as NOP, and BNE r1,r2 -> 13 only with macro.
REQ-037 JMP 0xFFF, then HALT -> halted=1, imem_req stays 0 for 20 cycles; ADDI r0,r0,7 -> r0 reads 0.
REQ-038 rst_n low during MEM wait -> dmem_req=0 next cycle, pc=0, late ack ignored, first fetch at address 0.
